// File: rtl/vlog_regfile_arb.sv
// vlog_regfile_arb: round-robin arbiter sequencing one read or write per grant into a shared register array
module vlog_regfile_arb #(
  parameter int NREQ = 4,
  parameter int AW = 5,
  parameter int DW = 8,
  parameter int DEPTH = 32,
  localparam int IW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               rvalid,
  output logic [IW-1:0]      rid,
  output logic [DW-1:0]      rdata,
  output logic               busy
);
  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS} state_t;
  state_t state_q;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] cnt_q, addr_q;
  logic [IW-1:0] ptr_q, w_q, rid_q, win_d, idx_d;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [NREQ-1:0] gnt_q;
  logic we_q, rvalid_q, busy_q, found_d;
  // descending scan so the requester closest to ptr is the last to overwrite win_d
  always_comb begin
    win_d = '0;
    idx_d = '0;
    found_d = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_d = IW'((int'(ptr_q) + k) % NREQ);
      if (req[idx_d]) begin
        win_d = idx_d;
        found_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    rvalid_q <= 1'b0;
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      ptr_q <= '0;
      gnt_q <= '0;
      rid_q <= '0;
      rdata_q <= '0;
      busy_q <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          mem[cnt_q] <= '0;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
        end
        IDLE: if (found_d) begin
          w_q <= win_d;
          we_q <= we[win_d];
          addr_q <= addr[win_d*AW +: AW];
          wdata_q <= wdata[win_d*DW +: DW];
          gnt_q <= NREQ'(1) << win_d;
          busy_q <= 1'b1;
          state_q <= ACCESS;
        end
        default: begin
          gnt_q <= '0;
          if (we_q) mem[addr_q] <= wdata_q;
          else begin
            rdata_q <= mem[addr_q];
            rid_q <= w_q;
            rvalid_q <= 1'b1;
          end
          ptr_q <= (w_q == IW'(NREQ - 1)) ? '0 : w_q + 1'b1;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign gnt = gnt_q;
  assign rvalid = rvalid_q;
  assign rid = rid_q;
  assign rdata = rdata_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_vlog_regfile_arb.sv
// tb_vlog_regfile_arb: randomized and directed scoreboard bench for vlog_regfile_arb
module tb_vlog_regfile_arb;
  localparam int NREQ = 4, AW = 5, DW = 8, DEPTH = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0, we = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0] gnt;
  logic rvalid, busy;
  logic [1:0] rid;
  logic [DW-1:0] rdata;
  vlog_regfile_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rid(rid), .rdata(rdata), .busy(busy));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {bit w; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
  typedef struct {int c; int g;} gexp_t;
  typedef struct {int c; int id; logic [DW-1:0] d;} rexp_t;
  op_t opq [NREQ][$];
  gexp_t gq[$], glog[$];
  rexp_t rq[$], rlog[$];
  int total = 0, bad = 0;
  // reference model: timeline of clear / idle / access phases plus storage contents
  int mphase = 0, mcnt = 0, mptr = 0, mw = 0, gw = -1;
  bit mwe;
  logic [AW-1:0] ma;
  logic [DW-1:0] md, erdata = '0;
  logic [DW-1:0] mmem [DEPTH];
  bit ebusy = 1'b1;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic fail_now(string n);
    total++;
    bad++;
    $display("FAIL %s: got no/unexpected event (cycle %0d)", n, cyc);
  endtask
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = opq[i].size() > 0;
      we[i] = req[i] ? opq[i][0].w : 1'b0;
      addr[i*AW +: AW] = req[i] ? opq[i][0].a : '0;
      wdata[i*DW +: DW] = req[i] ? opq[i][0].d : '0;
    end
  endtask
  task automatic model_edge();
    gexp_t g;
    rexp_t r;
    if (rst) begin
      mphase = 0; mcnt = 0; mptr = 0; ebusy = 1'b1; erdata = '0;
      return;
    end
    case (mphase)
      0: begin
        mmem[mcnt] = '0;
        mcnt++;
        if (mcnt == DEPTH) begin mphase = 1; ebusy = 1'b0; end
      end
      1: if (req != 0) begin
        for (int k = 0; k < NREQ; k++)
          if (req[(mptr + k) % NREQ]) begin mw = (mptr + k) % NREQ; break; end
        g.c = cyc + 1; g.g = 1 << mw;
        gq.push_back(g);
        mwe = we[mw]; ma = addr[mw*AW +: AW]; md = wdata[mw*DW +: DW];
        mphase = 2; ebusy = 1'b1; gw = mw;
      end
      default: begin
        if (mwe) mmem[ma] = md;
        else begin
          r.c = cyc + 1; r.id = mw; r.d = mmem[ma];
          rq.push_back(r);
          erdata = mmem[ma];
        end
        mptr = (mw + 1) % NREQ; mphase = 1; ebusy = 1'b0;
      end
    endcase
  endtask
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (gw >= 0) begin void'(opq[gw].pop_front()); gw = -1; end
    drive();
  endtask
  task automatic push_op(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    op_t o;
    o.w = w; o.a = a; o.d = d;
    opq[i].push_back(o);
    drive();
  endtask
  task automatic count_busy();
    int n = 0;
    while (busy && n < 100) begin n++; tick(); end
    chk("busy_cycles", n, 32);
  endtask
  task automatic reset_clear();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    count_busy();
  endtask
  task automatic wait_done();
    int n = 0;
    bit pend = 1'b1;
    while (pend && n < 300) begin
      pend = mphase != 1 || gq.size() > 0 || rq.size() > 0;
      for (int i = 0; i < NREQ; i++) if (opq[i].size() > 0) pend = 1'b1;
      if (pend) begin tick(); n++; end
    end
    if (pend) fail_now("timeout");
  endtask
  gexp_t ge;
  rexp_t re;
  always begin
    @(posedge clk);
    #2;
    chk("busy", busy, ebusy);
    if (gq.size() > 0 && gq[0].c < cyc) begin void'(gq.pop_front()); fail_now("gnt_missing"); end
    if (rq.size() > 0 && rq[0].c < cyc) begin void'(rq.pop_front()); fail_now("rvalid_missing"); end
    if (gnt != 0) begin
      ge.c = cyc; ge.g = gnt;
      glog.push_back(ge);
      if (gq.size() == 0 || gq[0].c != cyc) fail_now("gnt_unexpected");
      else begin ge = gq.pop_front(); chk("gnt", gnt, ge.g); end
    end
    if (rvalid) begin
      re.c = cyc; re.id = rid; re.d = rdata;
      rlog.push_back(re);
      if (rq.size() == 0 || rq[0].c != cyc) fail_now("rvalid_unexpected");
      else begin
        re = rq.pop_front();
        chk("rid", rid, re.id);
        chk("rdata", rdata, re.d);
      end
    end else chk("rdata_hold", rdata, erdata);
  end
  initial begin
    int gl, rn;
    reset_clear();
    push_op(0, 1'b0, 5'd17, 8'h00);
    wait_done();
    chk("t1_gnt", glog[glog.size()-1].g, 4'b0001);
    chk("t1_rid", rlog[rlog.size()-1].id, 0);
    chk("t1_rdata", rlog[rlog.size()-1].d, 8'h00);
    rn = rlog.size();
    push_op(1, 1'b1, 5'd3, 8'hA5);
    wait_done();
    chk("wr_gnt", glog[glog.size()-1].g, 4'b0010);
    chk("wr_no_rvalid", rlog.size(), rn);
    push_op(2, 1'b0, 5'd3, 8'h00);
    wait_done();
    chk("rd_gnt", glog[glog.size()-1].g, 4'b0100);
    chk("rd_rid", rlog[rlog.size()-1].id, 2);
    chk("rd_rdata", rlog[rlog.size()-1].d, 8'hA5);
    reset_clear();
    gl = glog.size();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) push_op(i, 1'(i % 2), 5'(i + 8), 8'($urandom));
    wait_done();
    chk("rr_count", glog.size() - gl, 8);
    for (int j = 0; j < 8 && gl + j < glog.size(); j++) begin
      chk("rr_order", glog[gl+j].g, 1 << (j % 4));
      if (j > 0) chk("rr_spacing", glog[gl+j].c - glog[gl+j-1].c, 2);
    end
    gl = glog.size();
    push_op(3, 1'b0, 5'd1, 8'h00);
    push_op(1, 1'b0, 5'd2, 8'h00);
    wait_done();
    chk("wrap_count", glog.size() - gl, 2);
    if (glog.size() >= gl + 2) begin
      chk("wrap_first", glog[gl].g, 4'b0010);
      chk("wrap_second", glog[gl+1].g, 4'b1000);
    end
    push_op(0, 1'b1, 5'd9, 8'h5A);
    for (int n = 0; n < 10 && mphase != 2; n++) tick();
    chk("mid_in_access", gnt, 4'b0001);
    rn = rlog.size();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy();
    chk("mid_no_rvalid", rlog.size(), rn);
    push_op(0, 1'b0, 5'd9, 8'h00);
    wait_done();
    chk("mid_rdata", rlog[rlog.size()-1].d, 8'h00);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int i = $urandom_range(0, NREQ - 1);
        if (opq[i].size() < 3) push_op(i, 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom));
      end
      tick();
    end
    wait_done();
    push_op(3, 1'b1, 5'd30, 8'h3C);
    wait_done();
    push_op(1, 1'b0, 5'd30, 8'h00);
    wait_done();
    chk("hold_src", rlog[rlog.size()-1].d, 8'h3C);
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("idle_gnt", gnt, 4'b0000);
      chk("idle_rvalid", rvalid, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_rdata", rdata, 8'h3C);
    end
    chk("gq_empty", gq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
